clock_phase_shifter: RTL and testbench
======================================

CLOCK_PHASE_SHIFTER -- requirements
Module: clock_phase_shifter

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 1 bit.
REQ-002 SHALL have port i_clk_2f, input, 1 bit: the only clock, running at twice the LO frequency (2f); both edges are used.
REQ-003 SHALL have port i_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port i_enable, input, 1 bit: request to run the quadrature outputs.
REQ-005 SHALL have port i_swap, input, 1 bit: exchanges the I and Q outputs, which selects the opposite sideband.
REQ-006 SHALL have port o_clk_i, output, 1 bit: in-phase clock at f.
REQ-007 SHALL have port o_clk_q, output, 1 bit: quadrature clock at f.
REQ-008 SHALL have port o_running, output, 1 bit: high while the outputs are toggling.

Function
REQ-009 SHALL hold these internal registers: i_ff (posedge), q_ff (negedge), run (posedge) and swap_lat (posedge).
REQ-010 On posedge, when idle (run=0) and i_enable=1: SHALL set run<=1 and swap_lat<=i_swap; i_ff stays 0.
REQ-011 On posedge, when run=1: SHALL toggle i_ff, except as stated in REQ-012.
REQ-012 On posedge, when run=1, i_enable=0 and i_ff=0: SHALL clear run and hold i_ff=0 (no toggle). Stopping therefore always occurs with both clocks low, and no output pulse is truncated.
REQ-013 On posedge, when run=1, i_enable=0 and i_ff=1: SHALL toggle i_ff to 0 and stop on the following posedge.
REQ-014 On every negedge: SHALL set q_ff<=i_ff. Q lags I by half an input period, which is 90 degrees at f.
REQ-015 SHALL drive o_clk_i = swap_lat ? q_ff : i_ff and o_clk_q = swap_lat ? i_ff : q_ff.
REQ-016 SHALL sample i_swap only on the idle-to-run transition; changes to i_swap while running SHALL be ignored until the next start.
REQ-017 SHALL drive o_running = run.
REQ-018 While running, each output SHALL have 50% duty cycle and a period of 2 i_clk_2f cycles.
REQ-019 SHALL produce the first rising edge of I one posedge after run rises (latency 2 posedges from i_enable sampled high).
REQ-020 SHALL produce Q's first rising edge at the following negedge.
REQ-021 When idle, all outputs SHALL be static low.

Reset
REQ-022 At posedge with i_reset_n=0: SHALL set i_ff=0, run=0 and swap_lat=0.
REQ-023 At negedge with i_reset_n=0: SHALL set q_ff=0.
REQ-024 SHALL drive o_clk_i=0, o_clk_q=0 and o_running=0 within one full input cycle of reset assertion.
REQ-025 Reset SHALL take priority over i_enable and SHALL abort immediately mid-operation, with no graceful stop.
REQ-026 After reset deasserts, the block SHALL be idle and SHALL start per REQ-010.
REQ-027 SHALL contain no asynchronous logic; FPGA global set/reset and power-up primitives are tied to the top-level reset and are outside this block.

Structure
REQ-028 SHALL be a single module with no sub-modules.
REQ-029 SHALL need no shared package.
REQ-030 SHALL use only the two edge processes (posedge and negedge of i_clk_2f) plus combinational output muxing.

Verification
REQ-031 Reset: hold i_reset_n=0 for 3 cycles with i_enable=1 -> o_clk_i=o_clk_q=o_running=0 throughout.
REQ-032 Start: release reset, i_enable=1, i_swap=0 -> o_running=1 after posedge 1; o_clk_i rises at posedge 2; o_clk_q rises at the next negedge; then both have period = 2 input cycles.
REQ-033 Quadrature: over 16 input cycles, every o_clk_i edge SHALL be followed by the same-direction o_clk_q edge exactly half an input cycle later.
REQ-034 Stop: drop i_enable while o_clk_i=1 -> I falls at the next posedge; o_running falls one posedge later; Q falls half a cycle after I; all outputs then stay 0.
REQ-035 Swap: start with i_swap=1 -> o_clk_q leads o_clk_i by half an input cycle. Toggling i_swap while running SHALL change nothing until a stop and restart.
REQ-036 Mid-run reset: assert i_reset_n=0 while o_clk_i=1 -> outputs SHALL be 0 within one input cycle; after release with i_enable=1 the start timing SHALL repeat REQ-032.

Source files
------------

// File: rtl/clock_phase_shifter.sv
// -----------------------------------------------------------------------------
// clock_phase_shifter
//
// Purpose:
//   Generates a quadrature clock pair (I and Q) at f from a single input
//   clock running at 2f. I toggles on the rising edge of the input clock,
//   and Q copies I on the falling edge. Q therefore lags I by half an input
//   period, which is 90 degrees at f. The i_swap input, sampled only when a
//   run starts, exchanges the two outputs to select the opposite sideband.
//   A run always stops with both outputs low, so no output pulse is cut
//   short. Reset is synchronous and aborts a run immediately.
//
// Ports:
//   i_clk_2f   in   1  clock at 2f; both edges are used
//   i_reset_n  in   1  synchronous active-low reset
//   i_enable   in   1  request to run the quadrature outputs
//   i_swap     in   1  exchange I and Q; sampled on the idle-to-run step
//   o_clk_i    out  1  in-phase clock at f
//   o_clk_q    out  1  quadrature clock at f
//   o_running  out  1  high while the outputs are toggling
// -----------------------------------------------------------------------------
module clock_phase_shifter (
    input  logic i_clk_2f,
    input  logic i_reset_n,
    input  logic i_enable,
    input  logic i_swap,
    output logic o_clk_i,
    output logic o_clk_q,
    output logic o_running
);

    logic i_ff;
    logic q_ff;
    logic run;
    logic swap_lat;

    // Rising edge: run control and the in-phase divider.
    always_ff @(posedge i_clk_2f) begin
        if (!i_reset_n) begin
            i_ff     <= 1'b0;
            run      <= 1'b0;
            swap_lat <= 1'b0;
        end else if (!run) begin
            // Starting holds I low for one more edge, so the first rising
            // edge of I comes one posedge after run rises.
            i_ff <= 1'b0;
            if (i_enable) begin
                run      <= 1'b1;
                swap_lat <= i_swap;
            end
        end else if (!i_enable && !i_ff) begin
            // Stop only from the low phase of I. If I is high, it first
            // toggles low through the branch below and stops one edge later.
            run  <= 1'b0;
            i_ff <= 1'b0;
        end else begin
            i_ff <= ~i_ff;
        end
    end

    // Falling edge: Q follows I half an input period later.
    always_ff @(negedge i_clk_2f) begin
        if (!i_reset_n) begin
            q_ff <= 1'b0;
        end else begin
            q_ff <= i_ff;
        end
    end

    always_comb begin
        o_clk_i   = swap_lat ? q_ff : i_ff;
        o_clk_q   = swap_lat ? i_ff : q_ff;
        o_running = run;
    end

endmodule

// File: tb/tb_clock_phase_shifter.sv
// -----------------------------------------------------------------------------
// tb_clock_phase_shifter
//
// Directed bench for clock_phase_shifter. Inputs change 1 time unit after a
// clock edge. Outputs are sampled 1 time unit after each posedge and each
// negedge, and compared with hand-derived values. Timing reference: the
// posedge that first samples i_enable high is edge 1. Without swap, after
// posedge k (k >= 2) I = (k even) and Q = (k odd). After the following
// negedge, both outputs equal (k even).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_phase_shifter;

    logic clk;
    logic reset_n;
    logic enable;
    logic swap;
    logic clk_i;
    logic clk_q;
    logic running;

    int n_tests;
    int n_fail;

    clock_phase_shifter dut (
        .i_clk_2f  (clk),
        .i_reset_n (reset_n),
        .i_enable  (enable),
        .i_swap    (swap),
        .o_clk_i   (clk_i),
        .o_clk_q   (clk_q),
        .o_running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic ei, input logic eq, input logic er);
        check_eq({tag, ".i"},   clk_i,   ei);
        check_eq({tag, ".q"},   clk_q,   eq);
        check_eq({tag, ".run"}, running, er);
    endtask

    task automatic pos_chk(input string tag, input logic ei, input logic eq, input logic er);
        @(posedge clk);
        #1;
        check_outs($sformatf("%s.pos", tag), ei, eq, er);
    endtask

    task automatic neg_chk(input string tag, input logic ei, input logic eq, input logic er);
        @(negedge clk);
        #1;
        check_outs($sformatf("%s.neg", tag), ei, eq, er);
    endtask

    // Start a run and check edges 1..last_k. The caller sets enable and swap
    // just after a negedge. With swapped=1, the leading clock is Q. When
    // flip_at is nonzero, i_swap is inverted after that edge and must have
    // no effect.
    task automatic run_from_start(input string tag, input logic swapped,
                                  input int last_k, input int flip_at);
        logic lead;
        logic lag;
        pos_chk($sformatf("%s.k1", tag), 1'b0, 1'b0, 1'b1);
        neg_chk($sformatf("%s.k1", tag), 1'b0, 1'b0, 1'b1);
        for (int k = 2; k <= last_k; k++) begin
            lead = (k % 2 == 0);
            lag  = (k % 2 == 1);
            if (swapped) pos_chk($sformatf("%s.k%0d", tag, k), lag, lead, 1'b1);
            else         pos_chk($sformatf("%s.k%0d", tag, k), lead, lag, 1'b1);
            neg_chk($sformatf("%s.k%0d", tag, k), lead, lead, 1'b1);
            if (k == flip_at) swap = ~swap;
        end
    endtask

    // Called just after the negedge of an even edge, when both outputs are
    // high. Drops enable and checks the graceful stop.
    task automatic stop_run(input string tag, input logic swapped);
        enable = 1'b0;
        // The leading clock falls first; the lagging clock is still high.
        if (swapped) pos_chk({tag, ".s1"}, 1'b1, 1'b0, 1'b1);
        else         pos_chk({tag, ".s1"}, 1'b0, 1'b1, 1'b1);
        neg_chk({tag, ".s1"}, 1'b0, 1'b0, 1'b1);
        pos_chk({tag, ".s2"}, 1'b0, 1'b0, 1'b0);
        neg_chk({tag, ".s2"}, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            pos_chk($sformatf("%s.idle%0d", tag, c), 1'b0, 1'b0, 1'b0);
            neg_chk($sformatf("%s.idle%0d", tag, c), 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        enable  = 1'b1;
        swap    = 1'b0;

        // Reset with enable high. The first cycle flushes unknown state;
        // outputs must then stay low for 3 more cycles.
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            pos_chk($sformatf("rst%0d", c), 1'b0, 1'b0, 1'b0);
            neg_chk($sformatf("rst%0d", c), 1'b0, 1'b0, 1'b0);
        end

        // Normal start, 16+ cycles of quadrature, then a stop with I high.
        reset_n = 1'b1;
        enable  = 1'b1;
        swap    = 1'b0;
        run_from_start("start", 1'b0, 18, 0);
        stop_run("stop", 1'b0);

        // Swapped start. Flip i_swap mid-run; it must be ignored.
        enable = 1'b1;
        swap   = 1'b1;
        run_from_start("swap", 1'b1, 8, 4);
        stop_run("swstop", 1'b1);

        // Restart with swap now low: normal order again.
        enable = 1'b1;
        swap   = 1'b0;
        run_from_start("restart", 1'b0, 6, 0);

        // Mid-run reset while I is high (after negedge of edge 6).
        reset_n = 1'b0;
        pos_chk("mrst", 1'b0, 1'b1, 1'b0);
        neg_chk("mrst", 1'b0, 1'b0, 1'b0);
        pos_chk("mrst2", 1'b0, 1'b0, 1'b0);
        neg_chk("mrst2", 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        enable  = 1'b1;
        run_from_start("postrst", 1'b0, 4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
